pci_initiator_ctrl: RTL
=======================

Name: pci_initiator_ctrl

Overview:
- PCI bus-master sequencer for one device. It sits between the device's local logic and the central bus arbiter.
- Drives the active-low REQ# line into the arbiter and consumes the arbiter's GNT#.
- Once granted and the bus is idle, it runs one address phase followed by a burst of 1..MAX_BURST data phases, read or write. It then releases the bus.
- Handles master abort when no target claims the transaction via DEVSEL#.

Parameters:
DATA_W, 32, width of AD bus and local data ports
CNT_W, 4, width of burst-length count (MAX_BURST = 2**CNT_W - 1 = 15)
DEVSEL_TO, 5, clocks after address phase with DEVSEL# high before master abort

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse: begin transaction with cmd/addr/count
cmd  in  4  PCI bus command; cmd[0]=1 write, cmd[0]=0 read
addr  in  DATA_W  transaction start address
count  in  CNT_W  number of data phases; 0 means start is ignored
wr_data  in  DATA_W  write data for current data phase, held by local logic until wr_pop
wr_pop  out  1  pulse: current wr_data word accepted by target
rd_data  out  DATA_W  read word captured from ad_in
rd_valid  out  1  pulse: rd_data valid
busy  out  1  high from accepted start until return to IDLE
done  out  1  pulse: transaction finished (normal or abort)
abort  out  1  pulse with done when master abort occurred
req_n  out  1  REQ# to arbiter
gnt_n  in  1  GNT# from arbiter
frame_in_n  in  1  observed bus FRAME#
irdy_in_n  in  1  observed bus IRDY#
trdy_n  in  1  target TRDY#
devsel_n  in  1  target DEVSEL#
frame_n  out  1  FRAME# drive value
irdy_n  out  1  IRDY# drive value
ad_out  out  DATA_W  AD drive value
ad_in  in  DATA_W  AD bus sampled value
ad_oe  out  1  AD/CBE drive enable
cbe_n  out  4  C/BE# drive value

Behaviour:
- All outputs are registered.
- Reset values: req_n=1, frame_n=1, irdy_n=1, ad_oe=0, ad_out=0, cbe_n=4'hF, wr_pop=0, rd_valid=0, rd_data=0, busy=0, done=0, abort=0. State=IDLE.
- rst asserted in any state returns everything to reset values at that edge; the bus is released immediately.
- States: IDLE, REQ, ADDR, DATA, TURN.
- IDLE: when start=1 and count!=0, latch cmd, addr and count into rem, then go to REQ. After that edge, req_n=0 and busy=1. start with count=0, or start in any other state, is ignored.
- REQ: hold req_n=0. Move to ADDR at the first edge that samples gnt_n=0, frame_in_n=1 and irdy_in_n=1. If grant is lost before then, stay in REQ.
- ADDR (exactly 1 cycle):
  - frame_n=0, ad_oe=1, ad_out=addr, cbe_n=cmd, req_n=1.
  - If rem==1, frame_n is already scheduled high for the first data cycle.
  - Clear the devsel timer.
- DATA:
  - irdy_n=0, cbe_n=4'h0 (all bytes).
  - Write: ad_oe=1, ad_out=wr_data. Read: ad_oe=0.
  - frame_n=0 while rem>1; frame_n=1 while rem==1 (last phase).
- Phase completion: an edge sampling irdy_n=0, trdy_n=0 and devsel_n=0.
  - Write: wr_pop=1 for the next cycle. Read: rd_data<=ad_in and rd_valid=1 for the next cycle.
  - rem decrements. If rem was 1, go to TURN with frame_n=1, irdy_n=1, ad_oe=0.
- Wait states: trdy_n=1 holds all drive values and rem unchanged.
- Devsel timer:
  - Counts DATA cycles while devsel_n=1 and has not yet been seen low.
  - Reaching DEVSEL_TO triggers master abort: go to TURN with abort flagged.
  - Once devsel_n has been seen low, the timer is frozen for the rest of the transaction.
- GNT removal after ADDR is ignored; the transaction completes.
- TURN (1 cycle): frame_n=1, irdy_n=1, ad_oe=0, cbe_n=4'hF. done=1 (abort=1 if aborted), busy still 1. Next state is IDLE with busy=0.
- Latencies:
  - Idle bus with gnt_n already 0: start at edge k gives req_n low after edge k, and frame_n low after edge k+1.
  - Minimum transaction is 1+1+1+count+1 cycles with zero wait states.

Test Plan:
- Write burst, count=3, target asserts devsel_n=0/trdy_n=0 each DATA cycle: ad_out carries addr then wr_data x3; 3 wr_pop pulses; frame_n high only on the 3rd data cycle; done after TURN; req_n high from ADDR on.
- Read, count=1, trdy_n delayed 2 wait states, ad_in=32'hDEADBEEF: frame_n=1 throughout DATA; irdy_n=0 for 3 cycles; rd_data=32'hDEADBEEF with one rd_valid pulse.
- No target (devsel_n stuck 1), DEVSEL_TO=5: after 5 DATA cycles, abort=1 and done=1 in the same cycle; no wr_pop or rd_valid; bus released.
- Grant contention: gnt_n=0 but frame_in_n=0 for 4 cycles: state stays REQ with frame_n=1; frame_n drops 1 cycle after frame_in_n and irdy_in_n return high.
- Edge cases: start with count=0 causes no req_n; start while busy is ignored; rst in mid-DATA of a 5-beat write gives all reset values at the next edge, with ad_oe=0 and frame_n=1.

Source files
------------

// File: rtl/pci_initiator_ctrl.sv
// pci_initiator_ctrl
// Bus-master sequencer for one PCI device. It requests the bus from the
// central arbiter and waits for a grant on an idle bus. It then runs one
// address phase and a burst of 1..2**CNT_W-1 data phases, read or write,
// and releases the bus. If no target claims the transaction via DEVSEL#
// within DEVSEL_TO data cycles, it performs a master abort.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   start/cmd/addr/count  local request; count==0 requests are dropped
//   wr_data, wr_pop     write word for the current phase / accepted pulse
//   rd_data, rd_valid   captured read word / valid pulse
//   busy, done, abort   transaction status
//   req_n, gnt_n        arbiter handshake
//   frame_in_n, irdy_in_n  observed bus FRAME#/IRDY# (bus-idle detect)
//   trdy_n, devsel_n    target responses
//   frame_n, irdy_n, ad_out, ad_oe, cbe_n  master drive values
//   ad_in               sampled AD bus
//   fsm_state           current state encoding, for debug/checkers
//
// Local handshake
//   start is a single-cycle request. It is accepted only in IDLE with
//   count!=0, and busy rises on the following cycle. wr_data must be held
//   stable until the cycle in which wr_pop is high. wr_pop and rd_valid are
//   one-cycle pulses, one per completed data phase. There is no
//   back-pressure on the local side.
module pci_initiator_ctrl #(
  parameter int DATA_W    = 32,
  parameter int CNT_W     = 4,
  parameter int DEVSEL_TO = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        cmd,
  input  logic [DATA_W-1:0] addr,
  input  logic [CNT_W-1:0]  count,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_pop,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              done,
  output logic              abort,
  output logic              req_n,
  input  logic              gnt_n,
  input  logic              frame_in_n,
  input  logic              irdy_in_n,
  input  logic              trdy_n,
  input  logic              devsel_n,
  output logic              frame_n,
  output logic              irdy_n,
  output logic [DATA_W-1:0] ad_out,
  input  logic [DATA_W-1:0] ad_in,
  output logic              ad_oe,
  output logic [3:0]        cbe_n,
  output logic [2:0]        fsm_state
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_ADDR = 3'd2,
    ST_DATA = 3'd3,
    ST_TURN = 3'd4
  } state_t;

  localparam int TMR_W = $clog2(DEVSEL_TO + 1);

  state_t             state_q, state_d;
  logic [3:0]         cmd_q, cmd_d;
  logic [DATA_W-1:0]  addr_q, addr_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic               seen_q, seen_d;

  logic               req_n_d, frame_n_d, irdy_n_d, ad_oe_d;
  logic               wr_pop_d, rd_valid_d, busy_d, done_d, abort_d;
  logic [DATA_W-1:0]  ad_out_d, rd_data_d;
  logic [3:0]         cbe_n_d;

  logic               is_write;
  logic               phase_done;
  logic               devsel_expired;

  assign is_write   = cmd_q[0];
  // irdy_n is our own registered drive, so it is low in every DATA cycle.
  assign phase_done = !irdy_n && !trdy_n && !devsel_n;
  // The timer only advances until DEVSEL# has been seen once; after that a
  // target has claimed the cycle and the timer stays frozen.
  assign devsel_expired = !seen_q && devsel_n &&
                          (tmr_q == TMR_W'(DEVSEL_TO - 1));

  assign fsm_state = state_q;

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    tmr_d      = tmr_q;
    seen_d     = seen_q;
    req_n_d    = req_n;
    frame_n_d  = frame_n;
    irdy_n_d   = irdy_n;
    ad_oe_d    = ad_oe;
    ad_out_d   = ad_out;
    cbe_n_d    = cbe_n;
    rd_data_d  = rd_data;
    busy_d     = busy;
    wr_pop_d   = 1'b0;
    rd_valid_d = 1'b0;
    done_d     = 1'b0;
    abort_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && (count != '0)) begin
          state_d = ST_REQ;
          cmd_d   = cmd;
          addr_d  = addr;
          rem_d   = count;
          req_n_d = 1'b0;
          busy_d  = 1'b1;
        end
      end

      ST_REQ: begin
        // Granted and the bus is idle (no FRAME#, no IRDY#).
        if (!gnt_n && frame_in_n && irdy_in_n) begin
          state_d   = ST_ADDR;
          req_n_d   = 1'b1;
          frame_n_d = 1'b0;
          ad_oe_d   = 1'b1;
          ad_out_d  = addr_q;
          cbe_n_d   = cmd_q;
        end
      end

      ST_ADDR: begin
        state_d   = ST_DATA;
        irdy_n_d  = 1'b0;
        cbe_n_d   = 4'h0;
        // A single-phase burst drops FRAME# as IRDY# asserts.
        frame_n_d = (rem_q == CNT_W'(1));
        ad_oe_d   = is_write;
        if (is_write) ad_out_d = wr_data;
        tmr_d     = '0;
        seen_d    = 1'b0;
      end

      ST_DATA: begin
        if (!devsel_n) seen_d = 1'b1;
        if (is_write) ad_out_d = wr_data;
        if (phase_done) begin
          rem_d = rem_q - CNT_W'(1);
          if (is_write) begin
            wr_pop_d = 1'b1;
          end else begin
            rd_data_d  = ad_in;
            rd_valid_d = 1'b1;
          end
          if (rem_q == CNT_W'(1)) begin
            state_d   = ST_TURN;
            frame_n_d = 1'b1;
            irdy_n_d  = 1'b1;
            ad_oe_d   = 1'b0;
            cbe_n_d   = 4'hF;
            done_d    = 1'b1;
          end else begin
            // Next phase is the last one when two remain now.
            frame_n_d = (rem_q == CNT_W'(2));
          end
        end else if (devsel_expired) begin
          state_d   = ST_TURN;
          frame_n_d = 1'b1;
          irdy_n_d  = 1'b1;
          ad_oe_d   = 1'b0;
          cbe_n_d   = 4'hF;
          done_d    = 1'b1;
          abort_d   = 1'b1;
        end else if (!seen_q && devsel_n) begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end

      ST_TURN: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d   = ST_IDLE;
        req_n_d   = 1'b1;
        frame_n_d = 1'b1;
        irdy_n_d  = 1'b1;
        ad_oe_d   = 1'b0;
        cbe_n_d   = 4'hF;
        busy_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cmd_q    <= '0;
      addr_q   <= '0;
      rem_q    <= '0;
      tmr_q    <= '0;
      seen_q   <= 1'b0;
      req_n    <= 1'b1;
      frame_n  <= 1'b1;
      irdy_n   <= 1'b1;
      ad_oe    <= 1'b0;
      ad_out   <= '0;
      cbe_n    <= 4'hF;
      rd_data  <= '0;
      wr_pop   <= 1'b0;
      rd_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      abort    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      tmr_q    <= tmr_d;
      seen_q   <= seen_d;
      req_n    <= req_n_d;
      frame_n  <= frame_n_d;
      irdy_n   <= irdy_n_d;
      ad_oe    <= ad_oe_d;
      ad_out   <= ad_out_d;
      cbe_n    <= cbe_n_d;
      rd_data  <= rd_data_d;
      wr_pop   <= wr_pop_d;
      rd_valid <= rd_valid_d;
      busy     <= busy_d;
      done     <= done_d;
      abort    <= abort_d;
    end
  end

endmodule
